// File: rtl/detector_arbiter.sv
// Round-robin arbiter sharing one seizure detector among NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining DETECTOR_ARBITER_TIMEOUT_EN.
module detector_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int VSEL_W         = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*VSEL_W-1:0]  req_vsel,
  input  logic                       det_ready,
  input  logic                       det_result_valid,
  input  logic                       det_seizure,
  input  logic [15:0]                det_confidence,
  output logic                       det_start,
  output logic [VSEL_W-1:0]          det_vsel,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         done,
  output logic                       res_seizure,
  output logic [15:0]                res_confidence,
  output logic                       res_timeout,
  output logic                       busy
);
  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [VSEL_W-1:0]   det_vsel_q, det_vsel_d;
  logic                det_start_q, det_start_d;
  logic                res_seizure_q, res_seizure_d;
  logic [15:0]         res_conf_q, res_conf_d;
  logic                busy_q, busy_d;
  logic                win_found;
  logic [IDX_W-1:0]    win_idx;
  int                  cand;

`ifdef DETECTOR_ARBITER_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            res_timeout_q, res_timeout_d;
`endif

  // First requester found scanning upward from the one after last_served.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_q) + k) % NUM_REQ;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    owner_d       = owner_q;
    last_d        = last_q;
    det_vsel_d    = det_vsel_q;
    det_start_d   = 1'b0;
    done_d        = '0;
    res_seizure_d = res_seizure_q;
    res_conf_d    = res_conf_q;
`ifdef DETECTOR_ARBITER_TIMEOUT_EN
    wdog_d        = wdog_q;
    res_timeout_d = res_timeout_q;
`endif
    case (state_q)
      S_IDLE: if (win_found && det_ready) begin
        state_d     = S_START;
        grant_d     = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
        owner_d     = win_idx;
        det_vsel_d  = req_vsel[win_idx*VSEL_W +: VSEL_W];
        det_start_d = 1'b1;
      end
      S_START: begin
        state_d = S_WAIT;
`ifdef DETECTOR_ARBITER_TIMEOUT_EN
        wdog_d  = '0;
`endif
      end
      S_WAIT: begin
        // A real result beats a watchdog expiry in the same cycle.
        if (det_result_valid) begin
          state_d       = S_DONE;
          done_d        = grant_q;
          res_seizure_d = det_seizure;
          res_conf_d    = det_confidence;
`ifdef DETECTOR_ARBITER_TIMEOUT_EN
          res_timeout_d = 1'b0;
        end else if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          state_d       = S_DONE;
          done_d        = grant_q;
          res_seizure_d = 1'b0;
          res_conf_d    = '0;
          res_timeout_d = 1'b1;
        end else begin
          wdog_d = wdog_q + 1'b1;
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        last_d  = owner_q;
        grant_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      grant_q       <= '0;
      done_q        <= '0;
      owner_q       <= '0;
      last_q        <= IDX_W'(NUM_REQ - 1);
      det_vsel_q    <= '0;
      det_start_q   <= 1'b0;
      res_seizure_q <= 1'b0;
      res_conf_q    <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      done_q        <= done_d;
      owner_q       <= owner_d;
      last_q        <= last_d;
      det_vsel_q    <= det_vsel_d;
      det_start_q   <= det_start_d;
      res_seizure_q <= res_seizure_d;
      res_conf_q    <= res_conf_d;
      busy_q        <= busy_d;
    end
  end

`ifdef DETECTOR_ARBITER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q        <= '0;
      res_timeout_q <= 1'b0;
    end else begin
      wdog_q        <= wdog_d;
      res_timeout_q <= res_timeout_d;
    end
  end
  assign res_timeout = res_timeout_q;
`else
  assign res_timeout = 1'b0;
`endif

  assign det_start      = det_start_q;
  assign det_vsel       = det_vsel_q;
  assign grant          = grant_q;
  assign done           = done_q;
  assign res_seizure    = res_seizure_q;
  assign res_confidence = res_conf_q;
  assign busy           = busy_q;
endmodule

// File: tb/tb_detector_arbiter.sv
// Directed bench for detector_arbiter; timeout scenarios run when
// DETECTOR_ARBITER_TIMEOUT_EN is defined.
module tb_detector_arbiter;
  localparam int NR = 4;
  localparam int VW = 4;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req;
  logic [NR*VW-1:0] req_vsel;
  logic            det_ready, det_result_valid, det_seizure;
  logic [15:0]     det_confidence;
  logic            det_start;
  logic [VW-1:0]   det_vsel;
  logic [NR-1:0]   grant, done;
  logic            res_seizure, res_timeout, busy;
  logic [15:0]     res_confidence;

  int checks = 0;
  int errors = 0;

  detector_arbiter #(.NUM_REQ(NR), .VSEL_W(VW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_vsel(req_vsel),
    .det_ready(det_ready), .det_result_valid(det_result_valid),
    .det_seizure(det_seizure), .det_confidence(det_confidence),
    .det_start(det_start), .det_vsel(det_vsel), .grant(grant), .done(done),
    .res_seizure(res_seizure), .res_confidence(res_confidence),
    .res_timeout(res_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (det_start !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; req_vsel = '0; det_ready = 1'b0;
    det_result_valid = 1'b0; det_seizure = 1'b0; det_confidence = '0;
    repeat (2) tick();
    checks++;
    if ({det_start, det_vsel, grant, done, res_seizure, res_confidence, res_timeout, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got start=%b vsel=%h grant=%b done=%b seiz=%b conf=%h to=%b busy=%b required all zero",
               det_start, det_vsel, grant, done, res_seizure, res_confidence, res_timeout, busy);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fairness();
    logic [NR-1:0] eg;
    int n;
    req = 4'hF; det_ready = 1'b1;
    req_vsel = {4'd8, 4'd7, 4'd6, 4'd5};
    for (int k = 0; k < 5; k++) begin
      eg = 4'b0001 << (k % 4);
      wait_start(n);
      checks++;
      if (det_start !== 1'b1 || grant !== eg) begin
        errors++;
        $display("FAIL fair_grant_%0d got start=%b grant=%b required start=1 grant=%b", k, det_start, grant, eg);
      end
      checks++;
      if (det_vsel !== VW'((k % 4) + 5)) begin
        errors++;
        $display("FAIL fair_vsel_%0d got %0d required %0d", k, det_vsel, (k % 4) + 5);
      end
      if (k > 0) begin
        checks++;
        if (n != 2) begin
          errors++;
          $display("FAIL fair_back_to_back_%0d got %0d cycles after done required 2", k, n);
        end
      end
      tick(); tick();
      det_result_valid = 1'b1; det_seizure = k[0]; det_confidence = 16'(k + 1);
      tick();
      det_result_valid = 1'b0;
      if (k == 4) req = '0;
      checks++;
      if (done !== eg || res_confidence !== 16'(k + 1) || res_seizure !== k[0]) begin
        errors++;
        $display("FAIL fair_done_%0d got done=%b conf=%h seiz=%b required done=%b conf=%h seiz=%b",
                 k, done, res_confidence, res_seizure, eg, 16'(k + 1), k[0]);
      end
    end
    tick(); tick();
  endtask

  task automatic test_single();
    req = 4'b0001; req_vsel = '0; req_vsel[3:0] = 4'd4; det_ready = 1'b1;
    tick();
    checks++;
    if (det_start !== 1'b1 || det_vsel !== 4'd4 || grant !== 4'b0001 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_start got start=%b vsel=%0d grant=%b busy=%b required 1 4 0001 1", det_start, det_vsel, grant, busy);
    end
    tick();
    checks++;
    if (det_start !== 1'b0 || done !== '0) begin
      errors++;
      $display("FAIL single_start_pulse got start=%b done=%b required 0 0000", det_start, done);
    end
    tick(); tick();
    det_result_valid = 1'b1; det_seizure = 1'b1; det_confidence = 16'h00C0;
    tick();
    det_result_valid = 1'b0; det_seizure = 1'b0; det_confidence = '0; req = '0;
    checks++;
    if (done !== 4'b0001 || res_seizure !== 1'b1 || res_confidence !== 16'h00C0 || res_timeout !== 1'b0) begin
      errors++;
      $display("FAIL single_done got done=%b seiz=%b conf=%h to=%b required 0001 1 00c0 0", done, res_seizure, res_confidence, res_timeout);
    end
    tick();
    checks++;
    if (done !== '0 || grant !== '0 || busy !== 1'b0 || res_seizure !== 1'b1 || res_confidence !== 16'h00C0) begin
      errors++;
      $display("FAIL single_after got done=%b grant=%b busy=%b seiz=%b conf=%h required 0000 0000 0 1 00c0",
               done, grant, busy, res_seizure, res_confidence);
    end
    tick();
  endtask

  task automatic test_stall();
    logic bad;
    bad = 1'b0;
    det_ready = 1'b0; req = 4'b0100;
    repeat (10) begin
      tick();
      if (grant !== '0 || det_start !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL stall_hold got grant/start activity while det_ready=0 required none");
    end
    det_ready = 1'b1;
    tick();
    checks++;
    if (grant !== 4'b0100 || det_start !== 1'b1) begin
      errors++;
      $display("FAIL stall_release got grant=%b start=%b required 0100 1", grant, det_start);
    end
    tick();
    det_result_valid = 1'b1; det_seizure = 1'b0; det_confidence = 16'h1234;
    tick();
    det_result_valid = 1'b0; req = '0;
    checks++;
    if (done !== 4'b0100 || res_seizure !== 1'b0 || res_confidence !== 16'h1234) begin
      errors++;
      $display("FAIL stall_done got done=%b seiz=%b conf=%h required 0100 0 1234", done, res_seizure, res_confidence);
    end
    tick(); tick();
  endtask

  task automatic test_spurious();
    logic bad;
    bad = 1'b0;
    det_result_valid = 1'b1; det_seizure = 1'b1; det_confidence = 16'hFFFF;
    repeat (3) begin
      tick();
      if (done !== '0 || busy !== 1'b0) bad = 1'b1;
    end
    det_result_valid = 1'b0; det_seizure = 1'b0; det_confidence = '0;
    checks++;
    if (bad || res_seizure !== 1'b0 || res_confidence !== 16'h1234) begin
      errors++;
      $display("FAIL spurious got bad=%b seiz=%b conf=%h required 0 0 1234", bad, res_seizure, res_confidence);
    end
  endtask

  task automatic test_drop_and_vsel();
    req = 4'b0010; req_vsel[7:4] = 4'd9;
    tick();
    checks++;
    if (grant !== 4'b0010 || det_vsel !== 4'd9) begin
      errors++;
      $display("FAIL drop_grant got grant=%b vsel=%0d required 0010 9", grant, det_vsel);
    end
    req = '0; req_vsel[7:4] = 4'd3;
    tick(); tick();
    checks++;
    if (det_vsel !== 4'd9 || grant !== 4'b0010 || busy !== 1'b1) begin
      errors++;
      $display("FAIL vsel_hold got vsel=%0d grant=%b busy=%b required 9 0010 1", det_vsel, grant, busy);
    end
    det_result_valid = 1'b1; det_seizure = 1'b1; det_confidence = 16'h0042;
    tick();
    det_result_valid = 1'b0; det_seizure = 1'b0; det_confidence = '0;
    checks++;
    if (done !== 4'b0010 || res_confidence !== 16'h0042) begin
      errors++;
      $display("FAIL drop_done got done=%b conf=%h required 0010 0042", done, res_confidence);
    end
    tick(); tick();
  endtask

`ifdef DETECTOR_ARBITER_TIMEOUT_EN
  task automatic test_timeout();
    logic bad;
    bad = 1'b0;
    req = 4'b1000;
    tick();
    checks++;
    if (det_start !== 1'b1 || grant !== 4'b1000) begin
      errors++;
      $display("FAIL timeout_grant got start=%b grant=%b required 1 1000", det_start, grant);
    end
    repeat (16) begin
      tick();
      if (done !== '0) bad = 1'b1;
    end
    tick();
    req = '0;
    checks++;
    if (bad || done !== 4'b1000 || res_timeout !== 1'b1 || res_confidence !== '0 || res_seizure !== 1'b0) begin
      errors++;
      $display("FAIL timeout_done got early=%b done=%b to=%b conf=%h seiz=%b required 0 1000 1 0000 0",
               bad, done, res_timeout, res_confidence, res_seizure);
    end
    tick(); tick();
    bad = 1'b0;
    req = 4'b0001;
    tick();
    repeat (16) begin
      tick();
      if (done !== '0) bad = 1'b1;
    end
    det_result_valid = 1'b1; det_seizure = 1'b1; det_confidence = 16'h0077;
    tick();
    det_result_valid = 1'b0; det_seizure = 1'b0; det_confidence = '0; req = '0;
    checks++;
    if (bad || done !== 4'b0001 || res_timeout !== 1'b0 || res_confidence !== 16'h0077) begin
      errors++;
      $display("FAIL timeout_tie got early=%b done=%b to=%b conf=%h required 0 0001 0 0077",
               bad, done, res_timeout, res_confidence);
    end
    tick(); tick();
  endtask
`endif

  task automatic test_reset_in_wait();
    logic bad;
    bad = 1'b0;
    req = 4'b0100; det_ready = 1'b1;
    tick(); tick(); tick();
    rst_n = 1'b0; req = '0;
    repeat (2) begin
      tick();
      if (done !== '0) bad = 1'b1;
    end
    checks++;
    if (bad || {det_start, det_vsel, grant, done, res_seizure, res_confidence, res_timeout, busy} !== '0) begin
      errors++;
      $display("FAIL reset_wait got start=%b vsel=%h grant=%b done=%b seiz=%b conf=%h to=%b busy=%b required all zero",
               det_start, det_vsel, grant, done, res_seizure, res_confidence, res_timeout, busy);
    end
    rst_n = 1'b1; req = 4'b1000;
    tick();
    checks++;
    if (grant !== 4'b1000 || det_start !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_regrant got grant=%b start=%b busy=%b required 1000 1 1", grant, det_start, busy);
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_single();
    test_stall();
    test_spurious();
    test_drop_and_vsel();
`ifdef DETECTOR_ARBITER_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/detector_arbiter.md
DETECTOR_ARBITER -- requirements
Module: detector_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one seizure detector (2..8).
REQ-002 Parameter VSEL_W, default 4, width of each requester's test-vector index.
REQ-003 Parameter TIMEOUT_CYCLES, default 4096, watchdog limit in clocks for one classification.
REQ-004 Port clk  input  1  single system clock; all logic on rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 Port req  input  NUM_REQ  level request per requester, held until its done pulse.
REQ-007 Port req_vsel  input  NUM_REQ*VSEL_W  vector index per requester; requester i uses bits [i*VSEL_W +: VSEL_W].
REQ-008 Port det_ready  input  1  detector idle, able to accept a start.
REQ-009 Port det_result_valid  input  1  detector result strobe.
REQ-010 Port det_seizure  input  1  detector seizure decision, qualified by det_result_valid.
REQ-011 Port det_confidence  input  16  detector confidence, Q8.8, qualified by det_result_valid.
REQ-012 Port det_start  output  1  one-cycle start pulse to detector.
REQ-013 Port det_vsel  output  VSEL_W  registered vector index presented to detector.
REQ-014 Port grant  output  NUM_REQ  one-hot current owner, zero when idle.
REQ-015 Port done  output  NUM_REQ  one-cycle one-hot completion pulse to owner.
REQ-016 Port res_seizure  output  1  result decision, valid while done nonzero.
REQ-017 Port res_confidence  output  16  result confidence, valid while done nonzero.
REQ-018 Port res_timeout  output  1  result ended by watchdog, valid while done nonzero.
REQ-019 Port busy  output  1  high in any state except IDLE.

Function
REQ-020 FSM states SHALL be IDLE, START, WAIT, DONE; all outputs registered.
REQ-021 IDLE: when any req bit set and det_ready=1, SHALL pick winner by round-robin, load grant, latch winner's vsel into det_vsel, go START next cycle.
REQ-022 Round-robin: search SHALL start at index (last_served+1) mod NUM_REQ, wrapping; last_served resets to NUM_REQ-1 so requester 0 wins first.
REQ-023 START: det_start=1 for exactly this one cycle; next state WAIT.
REQ-024 WAIT: on det_result_valid=1, latch det_seizure/det_confidence, res_timeout=0, go DONE.
REQ-025 DONE: done=grant for one cycle with res_* stable; last_served=owner; grant cleared; next IDLE.
REQ-026 Latency: req sampled in IDLE at cycle N -> det_start high cycle N+1; det_result_valid at cycle K -> done high cycle K+1.
REQ-027 Minimum spacing: a requester kept asserted SHALL not be re-granted before the cycle after its done; back-to-back service of another requester SHALL begin from IDLE the cycle after DONE.
REQ-028 Requester dropping req mid-service SHALL not abort: classification completes and done still pulses.
REQ-029 det_result_valid outside WAIT SHALL be ignored.
REQ-030 det_ready=0 in IDLE SHALL hold arbitration; no grant issued.
REQ-031 req_vsel changes after latch SHALL not affect det_vsel until next grant.
REQ-032 res_* SHALL hold their last values between done pulses.

Reset
REQ-033 On rst_n low: state IDLE, det_start=0, det_vsel=0, grant=0, done=0, res_seizure=0, res_confidence=0, res_timeout=0, busy=0, last_served=NUM_REQ-1, watchdog=0.
REQ-034 Reset mid-classification SHALL abandon it with no done pulse; first post-reset grant follows REQ-022.

Configuration
REQ-035 Macro DETECTOR_ARBITER_TIMEOUT_EN defined: WAIT counts clocks from 0; reaching TIMEOUT_CYCLES without det_result_valid SHALL go DONE with res_timeout=1, res_seizure=0, res_confidence=0; counter clears on entering WAIT.
REQ-036 Macro undefined: no watchdog logic; WAIT exits only on det_result_valid; res_timeout constant 0.
REQ-037 Simultaneous result and timeout in same cycle: result SHALL win, res_timeout=0.

Verification
REQ-038 Single: req=0001, vsel0=4, det_ready=1, result 3 cycles after start with seizure=1, conf=0x00C0 -> det_start 1 cycle later, det_vsel=4, done=0001 with res_seizure=1, res_confidence=0x00C0.
REQ-039 Fairness: req=1111 held, detector answers each in 2 cycles -> grants in order 0,1,2,3,0; no requester served twice before all others.
REQ-040 Timeout (macro on, TIMEOUT_CYCLES=16): detector silent -> done=owner exactly 16 cycles after WAIT entry, res_timeout=1, res_confidence=0.
REQ-041 Stall: det_ready=0 with req=0100 for 10 cycles -> grant=0, det_start=0; det_ready=1 -> grant=0100 next cycle.
REQ-042 Reset in WAIT: rst_n low 2 cycles -> all outputs zero, no done; after release req=1000 only -> requester 3 granted.
REQ-043 Spurious strobe: det_result_valid in IDLE -> no done, res_* unchanged.
